// File: rtl/pdp8lxbrarb.sv
// pdp8lxbrarb: block-RAM arbiter between the PDP-8/L extended-memory
// controller (xbr*) and ARM examine/deposit registers; CPU always wins.
//
// Ports:
//   CLOCK, RESET            fpga clock, async active-high reset
//   armwrite                one-clock register write strobe
//   armraddr, armwaddr      ARM register read/write select
//   armwdata, armrdata      ARM write data / combinational read data
//   xbraddr, xbrwdat        CPU-side address / write data
//   xbrenab, xbrwena        CPU-side chip / write enable (levels)
//   xbrrdat                 CPU-side read data (pass-through of bmrdat)
//   bmaddr, bmwdat          block RAM address / write data
//   bmenab, bmwena          block RAM enable / write enable
//   bmrdat                  block RAM read data, one clock after enable

module pdp8lxbrarb #(
   parameter logic [11:0] VERSION = 12'h001
) (
   input  logic        CLOCK,
   input  logic        RESET,
   input  logic        armwrite,
   input  logic [1:0]  armraddr,
   input  logic [1:0]  armwaddr,
   input  logic [31:0] armwdata,
   output logic [31:0] armrdata,
   input  logic [14:0] xbraddr,
   input  logic [11:0] xbrwdat,
   input  logic        xbrenab,
   input  logic        xbrwena,
   output logic [11:0] xbrrdat,
   output logic [14:0] bmaddr,
   output logic [11:0] bmwdat,
   output logic        bmenab,
   output logic        bmwena,
   input  logic [11:0] bmrdat
);

   typedef enum logic [1:0] {
      IDLE,
      PEND,
      ISSUE,
      CAPT
   } state_t;

   state_t      state, state_n;
   logic [14:0] armaddr;
   logic [11:0] armwdat;
   logic [11:0] armrdat;
   logic        armiswr;
   logic        autoinc;
   logic        overrun;
   logic        cpuinflight;
   logic [7:0]  tmo;
   logic [15:0] cpucycles;
   logic [15:0] armstalls;
   logic        enab_d;
   logic        wena_d;

   logic        busy;
   logic        stall;
   logic        done;
   logic        wr1, wr2, wr3;
   logic        cpu_set;
   logic        cpu_clr;

   logic        unused_wdata;
   assign unused_wdata = ^armwdata[30:16];

   assign busy = (state != IDLE);
   assign wr1  = armwrite && (armwaddr == 2'd1);
   assign wr2  = armwrite && (armwaddr == 2'd2);
   assign wr3  = armwrite && (armwaddr == 2'd3);

   // a CPU read phase starts the read-modify-write; its write phase
   // ending (or a read with no write-back timing out) finishes it
   assign cpu_set = xbrenab && !enab_d && !xbrwena;
   assign cpu_clr = (!xbrenab && enab_d && wena_d)
                 || (cpuinflight && !xbrwena && (tmo == 8'd254));

   assign xbrrdat = bmrdat;

   always_comb begin
      state_n = state;
      stall   = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE:  if (wr2) state_n = PEND;
         PEND:  if (!cpuinflight && !xbrenab) state_n = ISSUE;
         ISSUE: begin
            if (xbrenab) begin
               state_n = PEND;
               stall   = 1'b1;
            end else if (armiswr) begin
               state_n = IDLE;
               done    = 1'b1;
            end else begin
               state_n = CAPT;
            end
         end
         CAPT: begin
            state_n = IDLE;
            done    = 1'b1;
         end
      endcase
   end

   always_comb begin
      bmaddr = 15'd0;
      bmwdat = 12'd0;
      bmenab = 1'b0;
      bmwena = 1'b0;
      if (xbrenab) begin
         bmaddr = xbraddr;
         bmwdat = xbrwdat;
         bmenab = 1'b1;
         bmwena = xbrwena;
      end else if (state == ISSUE) begin
         bmaddr = armaddr;
         bmwdat = armwdat;
         bmenab = 1'b1;
         bmwena = armiswr;
      end
   end

   always_comb begin
      armrdata = 32'd0;
      unique case (armraddr)
         2'd0: armrdata = 32'h58411000 | {20'd0, VERSION};
         2'd1: armrdata = {busy, overrun, 14'd0, autoinc, armaddr};
         2'd2: armrdata = {busy, 19'd0, armrdat};
         2'd3: armrdata = {cpucycles, armstalls};
      endcase
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state       <= IDLE;
         armaddr     <= 15'd0;
         armwdat     <= 12'd0;
         armrdat     <= 12'd0;
         armiswr     <= 1'b0;
         autoinc     <= 1'b0;
         overrun     <= 1'b0;
         cpuinflight <= 1'b0;
         tmo         <= 8'd0;
         cpucycles   <= 16'd0;
         armstalls   <= 16'd0;
         enab_d      <= 1'b0;
         wena_d      <= 1'b0;
      end else begin
         state  <= state_n;
         enab_d <= xbrenab;
         wena_d <= xbrwena;

         if (wr1 && !busy) begin
            armaddr <= armwdata[14:0];
            autoinc <= armwdata[15];
         end else if (done && autoinc) begin
            armaddr <= armaddr + 15'd1;
         end

         if (wr2 && !busy) begin
            armiswr <= !armwdata[31];
            armwdat <= armwdata[11:0];
         end

         if (wr3)
            overrun <= 1'b0;
         else if ((wr1 || wr2) && busy)
            overrun <= 1'b1;

         if (state == CAPT)
            armrdat <= bmrdat;

         if (cpu_set)
            cpuinflight <= 1'b1;
         else if (cpu_clr)
            cpuinflight <= 1'b0;

         if (!cpuinflight || xbrwena)
            tmo <= 8'd0;
         else
            tmo <= tmo + 8'd1;

         if (wr3)
            cpucycles <= 16'd0;
         else if (cpu_set && cpucycles != 16'hFFFF)
            cpucycles <= cpucycles + 16'd1;

         if (wr3)
            armstalls <= 16'd0;
         else if (stall && armstalls != 16'hFFFF)
            armstalls <= armstalls + 16'd1;
      end
   end

endmodule

// File: tb/tb_pdp8lxbrarb.sv
// tb_pdp8lxbrarb: directed bench for the block-RAM arbiter with a
// behavioural 32K x 12 synchronous RAM attached to the bm* side.

module tb_pdp8lxbrarb;

   logic        CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic        armwrite = 1'b0;
   logic [1:0]  armraddr = 2'd0;
   logic [1:0]  armwaddr = 2'd0;
   logic [31:0] armwdata = 32'd0;
   logic [31:0] armrdata;
   logic [14:0] xbraddr = 15'd0;
   logic [11:0] xbrwdat = 12'd0;
   logic        xbrenab = 1'b0;
   logic        xbrwena = 1'b0;
   logic [11:0] xbrrdat;
   logic [14:0] bmaddr;
   logic [11:0] bmwdat;
   logic        bmenab;
   logic        bmwena;
   logic [11:0] bmrdat = 12'd0;

   logic [11:0] mem [0:32767];

   int checks = 0;
   int errors = 0;
   int k;
   logic leak;

   pdp8lxbrarb dut (
      .CLOCK    (CLOCK),
      .RESET    (RESET),
      .armwrite (armwrite),
      .armraddr (armraddr),
      .armwaddr (armwaddr),
      .armwdata (armwdata),
      .armrdata (armrdata),
      .xbraddr  (xbraddr),
      .xbrwdat  (xbrwdat),
      .xbrenab  (xbrenab),
      .xbrwena  (xbrwena),
      .xbrrdat  (xbrrdat),
      .bmaddr   (bmaddr),
      .bmwdat   (bmwdat),
      .bmenab   (bmenab),
      .bmwena   (bmwena),
      .bmrdat   (bmrdat)
   );

   always #5 CLOCK = ~CLOCK;

   always @(posedge CLOCK) begin
      if (bmenab) begin
         if (bmwena) mem[bmaddr] <= bmwdat;
         bmrdat <= mem[bmaddr];
      end
   end

   task automatic step();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chkreg(input string tag, input logic [1:0] a,
                         input logic [31:0] exp);
      armraddr = a;
      #1;
      chk(tag, armrdata, exp);
   endtask

   task automatic regwr(input logic [1:0] a, input logic [31:0] d);
      armwaddr = a;
      armwdata = d;
      armwrite = 1'b1;
      step();
      armwrite = 1'b0;
   endtask

   initial begin
      // reset state
      #12;
      chk("rst_bmenab", {31'd0, bmenab}, 32'd0);
      chk("rst_bmaddr", {17'd0, bmaddr}, 32'd0);
      chkreg("rst_reg0", 2'd0, 32'h58411001);
      chkreg("rst_reg1", 2'd1, 32'h00000000);
      chkreg("rst_reg3", 2'd3, 32'h00000000);
      RESET = 1'b0;
      step();

      // deposit 0ABC at 00400 with autoinc, then examine it
      regwr(2'd1, 32'h00008100);
      chkreg("dep_reg1", 2'd1, 32'h00008100);
      regwr(2'd2, 32'h00000ABC);
      chkreg("dep_busy", 2'd1, 32'h80008100);
      chk("dep_pend_en", {31'd0, bmenab}, 32'd0);
      step();
      chk("dep_iss_wena", {31'd0, bmwena}, 32'd1);
      chk("dep_iss_addr", {17'd0, bmaddr}, 32'h100);
      chk("dep_iss_wdat", {20'd0, bmwdat}, 32'hABC);
      step();
      chk("dep_wena_off", {31'd0, bmwena}, 32'd0);
      chkreg("dep_autoinc", 2'd1, 32'h00008101);
      regwr(2'd1, 32'h00000100);
      regwr(2'd2, 32'h80000000);
      step();
      step();
      chkreg("exa_busy_e2", 2'd2, 32'h80000000);
      step();
      chkreg("exa_data_e3", 2'd2, 32'h00000ABC);

      // autoinc wraps 77777 -> 00000
      regwr(2'd1, 32'h0000FFFF);
      regwr(2'd2, 32'h00000123);
      step();
      step();
      chkreg("wrap_reg1", 2'd1, 32'h00008000);

      // CPU priority: ARM read held while a CPU RMW runs
      regwr(2'd1, 32'h00000200);
      regwr(2'd2, 32'h000005A5);
      step();
      step();
      xbraddr  = 15'h300;
      xbrenab  = 1'b1;
      xbrwena  = 1'b0;
      armwaddr = 2'd2;
      armwdata = 32'h80000000;
      armwrite = 1'b1;
      step();
      armwrite = 1'b0;
      leak = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bmenab && !xbrenab) leak = 1'b1;
      end
      xbrenab = 1'b0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (bmenab) leak = 1'b1;
      end
      xbrenab = 1'b1;
      xbrwena = 1'b1;
      xbrwdat = 12'h777;
      for (int i = 0; i < 5; i++) begin
         step();
         if (bmaddr != 15'h300) leak = 1'b1;
      end
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      step();
      chk("pri_after_fall", {31'd0, bmenab}, 32'd0);
      chk("pri_no_leak", {31'd0, leak}, 32'd0);
      step();
      chk("pri_arm_en", {31'd0, bmenab}, 32'd1);
      chk("pri_arm_addr", {17'd0, bmaddr}, 32'h200);
      step();
      step();
      chkreg("pri_arm_data", 2'd2, 32'h000005A5);
      chkreg("pri_cpucyc", 2'd3, 32'h00010000);
      xbraddr = 15'h300;
      xbrenab = 1'b1;
      step();
      chk("pri_cpu_rd", {20'd0, xbrrdat}, 32'h777);
      xbrwena = 1'b1;
      step();
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      step();

      // collision: CPU takes the RAM on the ISSUE clock
      regwr(2'd3, 32'd0);
      chkreg("col_clr3", 2'd3, 32'h00000000);
      regwr(2'd2, 32'h80000000);
      step();
      chk("col_iss_addr", {17'd0, bmaddr}, 32'h200);
      xbraddr = 15'h400;
      xbrwdat = 12'h111;
      xbrenab = 1'b1;
      xbrwena = 1'b1;
      #1;
      chk("col_cpu_addr", {17'd0, bmaddr}, 32'h400);
      chk("col_cpu_wdat", {20'd0, bmwdat}, 32'h111);
      step();
      xbrenab = 1'b0;
      xbrwena = 1'b0;
      chkreg("col_busy", 2'd1, 32'h80000200);
      step();
      chk("col_retry_addr", {17'd0, bmaddr}, 32'h200);
      chk("col_retry_en", {31'd0, bmenab}, 32'd1);
      step();
      step();
      chkreg("col_data", 2'd2, 32'h000005A5);
      chkreg("col_stalls", 2'd3, 32'h00000001);

      // overrun: second reg2 write on the next clock is dropped
      regwr(2'd2, 32'h00000222);
      regwr(2'd2, 32'h00000333);
      chk("ovr_wdat", {20'd0, bmwdat}, 32'h222);
      step();
      chkreg("ovr_flag", 2'd1, 32'h40000200);
      regwr(2'd2, 32'h80000000);
      step();
      step();
      step();
      chkreg("ovr_data", 2'd2, 32'h00000222);
      regwr(2'd3, 32'd0);
      chkreg("ovr_clear", 2'd1, 32'h00000200);

      // CPU read with no write-back: inflight times out
      xbraddr = 15'h500;
      xbrenab = 1'b1;
      step();
      step();
      xbrenab = 1'b0;
      regwr(2'd2, 32'h80000000);
      k = 0;
      for (int i = 1; i <= 300; i++) begin
         step();
         if (bmenab) begin
            k = i;
            break;
         end
      end
      chk("tmo_clocks", k, 254);
      step();
      step();
      chkreg("tmo_done", 2'd1, 32'h00000200);
      chkreg("tmo_cpucyc", 2'd3, 32'h00010000);

      // async reset during PEND
      regwr(2'd2, 32'h80000000);
      chkreg("rst_pend_busy", 2'd1, 32'h80000200);
      RESET = 1'b1;
      #1;
      chk("arst_bmenab", {31'd0, bmenab}, 32'd0);
      chkreg("arst_reg1", 2'd1, 32'h00000000);
      RESET = 1'b0;
      leak = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bmenab) leak = 1'b1;
      end
      chk("arst_no_access", {31'd0, leak}, 32'd0);

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule
